// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and sizes for the data-memory controller slice.
package mem_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2
  } mem_state_t;

  // Counter reload value for a latency parameter; a latency of 0 loads 0.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    if (lat > 0) begin
      return CNT_W'(lat - 1);
    end else begin
      return {CNT_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core load/store port: the core is the master, the memory controller the slave.
interface data_mem_ctrl_if;

  logic                       rd_mem;
  logic                       wr_mem;
  logic [mem_pkg::ADDR_W-1:0] address;
  logic [mem_pkg::DATA_W-1:0] data_o;
  logic [mem_pkg::DATA_W-1:0] data_i;
  logic                       data_stall;
  logic                       wbuf_valid;

  modport master (
    output rd_mem, wr_mem, address, data_o,
    input  data_i, data_stall, wbuf_valid
  );

  modport slave (
    input  rd_mem, wr_mem, address, data_o,
    output data_i, data_stall, wbuf_valid
  );

endinterface

// File: rtl/data_mem_ctrl_write_buffer.sv
// One-entry posted write buffer with drain counter and store-to-load lookup.
module write_buffer import mem_pkg::*; #(
  parameter int WRITE_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic [DATA_W-1:0] cap_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              valid,
  output logic              hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              commit,
  output logic [ADDR_W-1:0] commit_addr,
  output logic [DATA_W-1:0] commit_data
);

  localparam logic [CNT_W-1:0] WR_LOAD = lat_load(WRITE_LAT);

  logic              valid_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic [CNT_W-1:0]  drain_cnt_r;

  // The entry stays visible (hit/forward) through its commit cycle.
  assign valid       = valid_r;
  assign hit         = valid_r && (addr_r == lookup_addr);
  assign fwd_data    = data_r;
  assign commit      = valid_r && (drain_cnt_r == {CNT_W{1'b0}});
  assign commit_addr = addr_r;
  assign commit_data = data_r;

  // Entry register: a capture overrides the commit-clear of the old entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r     <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      data_r      <= {DATA_W{1'b0}};
      drain_cnt_r <= {CNT_W{1'b0}};
    end else if (capture) begin
      valid_r     <= 1'b1;
      addr_r      <= cap_addr;
      data_r      <= cap_data;
      drain_cnt_r <= WR_LOAD;
    end else if (commit) begin
      valid_r     <= 1'b0;
    end else if (valid_r) begin
      drain_cnt_r <= drain_cnt_r - 3'd1;
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: 32x8 array, posted write buffer, read wait-state FSM.
module data_mem_ctrl import mem_pkg::*; #(
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 3
) (
  input  logic          clk,
  input  logic          reset,
  data_mem_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] RD_LOAD = lat_load(READ_LAT);

  mem_state_t        state_r;
  mem_state_t        state_next_s;
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] raddr_r;
  logic [CNT_W-1:0]  rcnt_r;

  logic              rload_s;
  logic              rdec_s;
  logic              capture_s;
  logic              data_stall_s;
  logic [DATA_W-1:0] data_i_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic [DATA_W-1:0] rd_word_s;

  logic              wb_valid_s;
  logic              wb_hit_s;
  logic [DATA_W-1:0] wb_fwd_s;
  logic              wb_commit_s;
  logic [ADDR_W-1:0] wb_commit_addr_s;
  logic [DATA_W-1:0] wb_commit_data_s;

  write_buffer #(.WRITE_LAT(WRITE_LAT)) u_wbuf (
    .clk         (clk),
    .reset       (reset),
    .capture     (capture_s),
    .cap_addr    (bus.address),
    .cap_data    (bus.data_o),
    .lookup_addr (bus.address),
    .valid       (wb_valid_s),
    .hit         (wb_hit_s),
    .fwd_data    (wb_fwd_s),
    .commit      (wb_commit_s),
    .commit_addr (wb_commit_addr_s),
    .commit_data (wb_commit_data_s)
  );

  // Single read port: the latched address while waiting, otherwise the live one,
  // so a wait-state read samples the array at completion and sees late commits.
  assign rd_addr_s = (state_r == READ_WAIT) ? raddr_r : bus.address;
  assign rd_word_s = mem_r[rd_addr_s];

  assign bus.data_i     = data_i_s;
  assign bus.data_stall = data_stall_s;
  assign bus.wbuf_valid = wb_valid_s;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a write request always takes priority over a read.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.wr_mem) begin
          if (wb_valid_s && !wb_commit_s) begin
            state_next_s = WRITE_WAIT;
          end else begin
            state_next_s = IDLE;
          end
        end else if (bus.rd_mem && !wb_hit_s && (READ_LAT > 0)) begin
          state_next_s = READ_WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      READ_WAIT: begin
        if (!bus.rd_mem || (rcnt_r == 3'd0)) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = READ_WAIT;
        end
      end
      WRITE_WAIT: begin
        if (!bus.wr_mem || wb_commit_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WRITE_WAIT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output / control decode; outputs are held at zero while reset is asserted.
  always_comb begin
    capture_s    = 1'b0;
    rload_s      = 1'b0;
    rdec_s       = 1'b0;
    data_stall_s = 1'b0;
    data_i_s     = 8'h00;
    if (reset) begin
      data_stall_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.wr_mem) begin
            if (!wb_valid_s || wb_commit_s) begin
              capture_s = 1'b1;
            end else begin
              data_stall_s = 1'b1;
            end
          end else if (bus.rd_mem) begin
            if (wb_hit_s) begin
              data_i_s = wb_fwd_s;
            end else if (READ_LAT == 0) begin
              data_i_s = rd_word_s;
            end else begin
              data_stall_s = 1'b1;
              rload_s      = 1'b1;
            end
          end else begin
            data_i_s = 8'h00;
          end
        end
        READ_WAIT: begin
          if (!bus.rd_mem) begin
            data_i_s = 8'h00;
          end else if (rcnt_r != 3'd0) begin
            data_stall_s = 1'b1;
            rdec_s       = 1'b1;
          end else begin
            data_i_s = rd_word_s;
          end
        end
        WRITE_WAIT: begin
          if (!bus.wr_mem) begin
            data_stall_s = 1'b0;
          end else if (wb_commit_s) begin
            capture_s = 1'b1;
          end else begin
            data_stall_s = 1'b1;
          end
        end
        default: begin
          data_stall_s = 1'b0;
        end
      endcase
    end
  end

  // Read wait-state counter and latched read address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt_r  <= 3'd0;
      raddr_r <= {ADDR_W{1'b0}};
    end else if (rload_s) begin
      rcnt_r  <= RD_LOAD;
      raddr_r <= bus.address;
    end else if (rdec_s) begin
      rcnt_r  <= rcnt_r - 3'd1;
    end
  end

  // Storage array; its only writer is the buffer commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (wb_commit_s) begin
      mem_r[wb_commit_addr_s] <= wb_commit_data_s;
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory controller on the core's load/store port: 32×8 storage, one-entry posted write buffer with store-to-load forwarding, and a parameterised read wait-state FSM that drives `data_stall` back to the core. It consumes the core's `rd_mem`/`wr_mem`/`address`/`data_o`. It produces `data_i`/`data_stall`, replacing the flat zero-latency RAM.

## Interface
- `READ_LAT`, default 2: stall cycles per array read, 0..7; 0 = combinational read.
- `WRITE_LAT`, default 3: cycles a buffered write waits before committing to the array, 1..7.
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `rd_mem`  in  1  load request; held with `address` stable while `data_stall`=1
- `wr_mem`  in  1  store request; held with `address`/`data_o` stable while `data_stall`=1
- `address`  in  5  byte address
- `data_o`  in  8  store data from core
- `data_i`  out  8  load data; valid only in a cycle with `rd_mem`=1 and `data_stall`=0, else 8'h00
- `data_stall`  out  1  core must hold PC and request
- `wbuf_valid`  out  1  write buffer occupied (debug/perf)

## Operation
- Storage is a 32×8 array with 1 write port and 1 read port.
- Write buffer holds {valid, addr[4:0], data[7:0], drain_cnt[2:0]}.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT.
- **Simultaneous `rd_mem` and `wr_mem`:** write wins; the read is ignored and `data_i`=0.
- **IDLE, write, buffer empty:**
  - Capture {address, data_o}; `drain_cnt`<=WRITE_LAT-1; `data_stall`=0.
- **IDLE, write, buffer full:**
  - Assert `data_stall`=1 and go to WRITE_WAIT.
  - Exception: if the buffer commits this same cycle (`drain_cnt`==0), accept the write with no stall.
- **WRITE_WAIT:**
  - `data_stall`=1 until the cycle in which the buffer commits.
  - In that cycle: `data_stall`=0, the new write is captured, return to IDLE.
- **Buffer drain:**
  - While valid, `drain_cnt` decrements each cycle.
  - In the cycle `drain_cnt`==0: array[addr]<=data at the clock edge and valid clears, unless a new write is captured at the same edge.
- **IDLE, read, buffer hit** (valid && addr==address): `data_i`=buffer data, `data_stall`=0, no wait. Forwarding includes the commit cycle.
- **IDLE, read, miss, READ_LAT=0:** `data_i`=array[address], `data_stall`=0.
- **IDLE, read, miss, READ_LAT>0:**
  - Latch address into `raddr`; `rcnt`<=READ_LAT-1; `data_stall`=1; go to READ_WAIT.
- **READ_WAIT:**
  - If `rcnt`!=0: `data_stall`=1 and decrement.
  - If `rcnt`==0: `data_stall`=0, `data_i`=array[`raddr`], return to IDLE.
  - The buffer keeps draining during READ_WAIT. A read of a location committed during the wait returns the committed value, because the array read is taken at completion.
- **`rd_mem` dropped in READ_WAIT:** abort to IDLE, `data_stall`=0, `data_i`=0.
- A write requested during READ_WAIT is not permitted; the core is stalled.

## Timing
- Reset values:
  - FSM=IDLE; buffer valid=0; counters=0.
  - All array bytes=8'h00.
  - `data_i`=0, `data_stall`=0, `wbuf_valid`=0.
- Reset mid-operation discards any pending buffered write and any in-flight read.
- Read miss: exactly READ_LAT stall cycles; data on cycle READ_LAT+1 after the request first appears.
- Read hit or READ_LAT=0: zero stall, data in the same cycle.
- Store: zero stall if the buffer is empty. A store is visible in the array WRITE_LAT edges after capture; it is visible to loads immediately via forwarding.
- Back-to-back stores: the second stalls for the remaining `drain_cnt` cycles of the first.
- Counter widths are 3 bits; no wrap, because parameters are ≤7.
- `data_stall` and `data_i` are combinational from the FSM state, counters, buffer and inputs. There is no combinational path from `data_i` to `data_stall`.

## Structure
- Package `mem_pkg`:
  - `ADDR_W`=5, `DATA_W`=8.
  - `mem_state_t` enum {IDLE, READ_WAIT, WRITE_WAIT}.
- Sub-module `write_buffer`:
  - Holds the entry and the drain counter.
  - Outputs valid, hit, fwd_data, commit, commit_addr, commit_data.
  - The controller owns the FSM, the array and the read counter.

## Test plan
- Reset, then read addr 5 (READ_LAT=2) → `data_stall` high 2 cycles, then `data_i`=8'h00 with stall low.
- Store 8'hA5→addr 3, next cycle load addr 3 → no stall, `data_i`=8'hA5 (forwarded). After 3 cycles `wbuf_valid`=0 and the array holds 8'hA5.
- Store 8'h11→1 then immediately store 8'h22→2 (WRITE_LAT=3) → second store stalls 2 cycles. Then addr1=8'h11, and addr2 commits 3 cycles later.
- Store 8'h7E→9, then load addr 9 in the commit cycle → forwarded 8'h7E, no stall.
- Load miss addr 4, drop `rd_mem` after 1 stall cycle → FSM returns to IDLE, `data_i`=0, no spurious data.
- Assert `reset` during READ_WAIT with a buffered write pending → outputs 0 immediately. A subsequent read of the buffered address returns 8'h00.
